// File: rtl/sample_store_if.sv
// Sample-stream and read-port bundle for sample_store.
// The master side produces samples and read requests; the slave side
// (sample_store) returns FIFO status and registered read data.
interface sample_store_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_vld;
    logic                  rd_req;
    logic                  rd_rdy;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output sample_in,
        output sample_vld,
        output rd_req,
        input  rd_rdy,
        input  rd_data
    );

    modport slave (
        input  sample_in,
        input  sample_vld,
        input  rd_req,
        output rd_rdy,
        output rd_data
    );
endinterface

// File: rtl/sample_store.sv
// sample_store: armed capture of a fixed number of samples into a FIFO,
// with a downstream pop port and overflow / read-when-empty event pulses.
// Optional feature macro: SAMPLE_STORE_OVF_CNT_EN enables the saturating
// dropped-sample counter on ovf_cnt; without it ovf_cnt is constant zero.
module sample_store #(
    parameter int  DATA_WIDTH = 32,
    parameter int  FIFO_SIZE  = 1024,
    localparam int FW         = $clog2(FIFO_SIZE)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                arm,
    input  logic                flush,
    input  logic [FW:0]         capture_len,
    sample_store_if.slave       bus,
    output logic [FW:0]         fifo_count,
    output logic                busy,
    output logic                done,
    output logic                event_overflow,
    output logic                event_read_when_empty,
    output logic [15:0]         ovf_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [FW:0]   FULL_COUNT = (FW + 1)'(FIFO_SIZE);
    localparam logic [FW:0]   CNT_ONE    = (FW + 1)'(1);
    localparam logic [FW-1:0] PTR_ONE    = FW'(1);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
    logic [FW-1:0]         wr_ptr;
    logic [FW-1:0]         rd_ptr;
    logic [FW:0]           count;
    logic [FW:0]           cap_cnt;
    logic [FW:0]           len_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  ovf_q;
    logic                  rwe_q;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [FW:0]           cap_next;

    // Handshake decode: a pop frees a slot in the same cycle, so a full
    // FIFO can still accept a push when it is being read; flush masks both.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_COUNT);
        push_req   = (state == CAPTURE) && bus.sample_vld && !flush;
        pop        = bus.rd_req && !fifo_empty && !flush;
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
        cap_next   = cap_cnt + CNT_ONE;
    end

    // Capture FSM, FIFO pointers, occupancy, read register and event pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cap_cnt   <= '0;
            len_q     <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            rwe_q     <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cap_cnt <= '0;
            ovf_q   <= 1'b0;
            rwe_q   <= 1'b0;
        end else begin
            ovf_q <= drop;
            rwe_q <= bus.rd_req && fifo_empty;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                rd_data_q <= mem[rd_ptr];
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        len_q   <= capture_len;
                        cap_cnt <= '0;
                        state   <= (capture_len == '0) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (push) begin
                        cap_cnt <= cap_next;
                        if (cap_next == len_q) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.sample_in;
        end
    end

`ifdef SAMPLE_STORE_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Count each overflow pulse, holding at the maximum rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            ovf_cnt_q <= '0;
        end else if (ovf_q && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 16'h0000;
`endif

    assign bus.rd_rdy            = !fifo_empty;
    assign bus.rd_data           = rd_data_q;
    assign fifo_count            = count;
    assign busy                  = (state == CAPTURE);
    assign done                  = (state == DONE);
    assign event_overflow        = ovf_q;
    assign event_read_when_empty = rwe_q;

endmodule

// File: tb/tb_sample_store.sv
// Directed testbench for sample_store with an 8-word FIFO.
// Honours SAMPLE_STORE_OVF_CNT_EN when choosing the expected ovf_cnt value.
module tb_sample_store;

    localparam int DW = 32;
    localparam int FS = 8;
    localparam int FW = $clog2(FS);

`ifdef SAMPLE_STORE_OVF_CNT_EN
    localparam logic [31:0] OVF_EXP = 32'd2;
`else
    localparam logic [31:0] OVF_EXP = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          arm;
    logic          flush;
    logic [FW:0]   capture_len;
    logic [FW:0]   fifo_count;
    logic          busy;
    logic          done;
    logic          event_overflow;
    logic          event_read_when_empty;
    logic [15:0]   ovf_cnt;

    int compared   = 0;
    int mismatched = 0;

    sample_store_if #(.DATA_WIDTH(DW)) bus ();

    sample_store #(
        .DATA_WIDTH(DW),
        .FIFO_SIZE (FS)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .arm                  (arm),
        .flush                (flush),
        .capture_len          (capture_len),
        .bus                  (bus.slave),
        .fifo_count           (fifo_count),
        .busy                 (busy),
        .done                 (done),
        .event_overflow       (event_overflow),
        .event_read_when_empty(event_read_when_empty),
        .ovf_cnt              (ovf_cnt)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample #1 after the rising edge.
    task automatic applyStimulus(input logic a, input logic f, input logic [FW:0] len,
                                 input logic v, input logic [31:0] d, input logic r);
        arm            = a;
        flush          = f;
        capture_len    = len;
        bus.sample_vld = v;
        bus.sample_in  = d;
        bus.rd_req     = r;
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        rstn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_count", {28'd0, fifo_count}, 0);
        checkOutput("rst_rd_rdy", {31'd0, bus.rd_rdy}, 0);
        checkOutput("rst_rd_data", bus.rd_data, 0);
        checkOutput("rst_ovf_evt", {31'd0, event_overflow}, 0);
        checkOutput("rst_rwe_evt", {31'd0, event_read_when_empty}, 0);
        checkOutput("rst_ovf_cnt", {16'd0, ovf_cnt}, 0);
        rstn = 1'b1;

        // Capture of 4 with 6 samples offered: 5 and 6 ignored.
        applyStimulus(1, 0, 4, 0, 0, 0);
        checkOutput("arm_busy", {31'd0, busy}, 1);
        for (int v = 1; v <= 6; v++) applyStimulus(0, 0, 0, 1, v, 0);
        checkOutput("cap4_count", {28'd0, fifo_count}, 4);
        checkOutput("cap4_done", {31'd0, done}, 1);
        checkOutput("cap4_busy", {31'd0, busy}, 0);
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkOutput("cap4_read", bus.rd_data, v);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("cap4_empty", {28'd0, fifo_count}, 0);
        checkOutput("cap4_rd_rdy", {31'd0, bus.rd_rdy}, 0);

        // Read while empty.
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("rwe_pulse", {31'd0, event_read_when_empty}, 1);
        checkOutput("rwe_rd_data", bus.rd_data, 4);
        checkOutput("rwe_count", {28'd0, fifo_count}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rwe_clear", {31'd0, event_read_when_empty}, 0);

        // Overflow: capture_len 10, 10 samples, FIFO holds 8.
        applyStimulus(1, 0, 10, 0, 0, 0);
        for (int v = 101; v <= 108; v++) applyStimulus(0, 0, 0, 1, v, 0);
        checkOutput("ovf_count8", {28'd0, fifo_count}, 8);
        checkOutput("ovf_no_evt", {31'd0, event_overflow}, 0);
        applyStimulus(0, 0, 0, 1, 109, 0);
        checkOutput("ovf_evt1", {31'd0, event_overflow}, 1);
        applyStimulus(0, 0, 0, 1, 110, 0);
        checkOutput("ovf_evt2", {31'd0, event_overflow}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ovf_evt_clear", {31'd0, event_overflow}, 0);
        checkOutput("ovf_cnt", {16'd0, ovf_cnt}, OVF_EXP);
        checkOutput("ovf_busy", {31'd0, busy}, 1);
        checkOutput("ovf_count_hold", {28'd0, fifo_count}, 8);

        // Full FIFO with simultaneous push and pop.
        applyStimulus(0, 0, 0, 1, 111, 1);
        checkOutput("fullrw_count", {28'd0, fifo_count}, 8);
        checkOutput("fullrw_data", bus.rd_data, 101);
        checkOutput("fullrw_no_ovf", {31'd0, event_overflow}, 0);
        checkOutput("fullrw_busy", {31'd0, busy}, 1);
        applyStimulus(0, 0, 0, 1, 112, 1);
        checkOutput("fullrw_data2", bus.rd_data, 102);
        checkOutput("fullrw_done", {31'd0, done}, 1);
        for (int v = 103; v <= 108; v++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkOutput("drain_read", bus.rd_data, v);
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain_read", bus.rd_data, 111);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain_read", bus.rd_data, 112);
        checkOutput("drain_empty", {28'd0, fifo_count}, 0);

        // 20 words streamed through the 8-deep FIFO in two captures of 10.
        applyStimulus(1, 0, 10, 0, 0, 0);
        for (int v = 1; v <= 10; v++) begin
            applyStimulus(0, 0, 0, 1, v, 1);
            if (v == 1) begin
                checkOutput("stream_rwe", {31'd0, event_read_when_empty}, 1);
                checkOutput("stream_count1", {28'd0, fifo_count}, 1);
            end else begin
                checkOutput("stream_read", bus.rd_data, v - 1);
            end
            if (v == 2) checkOutput("stream_rwe_clear", {31'd0, event_read_when_empty}, 0);
        end
        checkOutput("stream_done1", {31'd0, done}, 1);
        applyStimulus(1, 0, 10, 0, 0, 0);
        checkOutput("stream_rearm", {31'd0, busy}, 1);
        checkOutput("stream_retain", {28'd0, fifo_count}, 1);
        for (int v = 11; v <= 20; v++) begin
            applyStimulus(0, 0, 0, 1, v, 1);
            checkOutput("stream_read", bus.rd_data, v - 1);
            checkOutput("stream_count", {28'd0, fifo_count}, 1);
        end
        checkOutput("stream_done2", {31'd0, done}, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("stream_last", bus.rd_data, 20);
        checkOutput("stream_empty", {28'd0, fifo_count}, 0);
        checkOutput("ovf_cnt_kept", {16'd0, ovf_cnt}, OVF_EXP);

        // Flush mid-capture after 3 samples; arm during capture ignored.
        applyStimulus(1, 0, 8, 0, 0, 0);
        for (int v = 7; v <= 9; v++) applyStimulus(0, 0, 0, 1, v, 0);
        checkOutput("fl_count3", {28'd0, fifo_count}, 3);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("arm_ignored", {31'd0, busy}, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("fl_busy", {31'd0, busy}, 0);
        checkOutput("fl_done", {31'd0, done}, 0);
        checkOutput("fl_count", {28'd0, fifo_count}, 0);
        checkOutput("fl_rd_rdy", {31'd0, bus.rd_rdy}, 0);
        checkOutput("fl_ovf_cnt", {16'd0, ovf_cnt}, 0);
        checkOutput("fl_rd_data", bus.rd_data, 20);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("len0_done", {31'd0, done}, 1);

        // Reset mid-capture after 3 samples.
        applyStimulus(1, 0, 8, 0, 0, 0);
        for (int v = 7; v <= 9; v++) applyStimulus(0, 0, 0, 1, v, 0);
        checkOutput("rs_count3", {28'd0, fifo_count}, 3);
        rstn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rs_busy", {31'd0, busy}, 0);
        checkOutput("rs_done", {31'd0, done}, 0);
        checkOutput("rs_count", {28'd0, fifo_count}, 0);
        checkOutput("rs_rd_rdy", {31'd0, bus.rd_rdy}, 0);
        checkOutput("rs_rd_data", bus.rd_data, 0);
        rstn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sample_store.md
SAMPLE_STORE -- requirements
Module: sample_store

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, sample/word width; FIFO_SIZE, default 1024, FIFO depth in words (power of 2); FW = $clog2(FIFO_SIZE).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 arm  input  1  single-cycle pulse that starts a capture.
REQ-005 flush  input  1  discards FIFO contents and returns FSM to IDLE.
REQ-006 capture_len  input  FW+1  number of samples to store per capture; sampled on arm.
REQ-007 sample_in  input  DATA_WIDTH  measurement sample.
REQ-008 sample_vld  input  1  sample_in is valid this cycle.
REQ-009 rd_req  input  1  downstream read request (pop).
REQ-010 rd_rdy  output  1  FIFO is not empty.
REQ-011 rd_data  output  DATA_WIDTH  registered read data.
REQ-012 fifo_count  output  FW+1  words currently stored.
REQ-013 busy  output  1  FSM in CAPTURE.
REQ-014 done  output  1  FSM in DONE.
REQ-015 event_overflow  output  1  one-cycle pulse: accepted sample dropped because FIFO full.
REQ-016 event_read_when_empty  output  1  one-cycle pulse: rd_req while rd_rdy low.
REQ-017 ovf_cnt  output  16  dropped-sample counter (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, CAPTURE, DONE, encoded in a registered state variable.
REQ-019 IDLE: arm -> CAPTURE; latch capture_len into len_q; clear capture counter cap_cnt; if capture_len==0 -> DONE instead.
REQ-020 CAPTURE: each cycle with sample_vld SHALL push sample_in if space exists and increment cap_cnt; when post-increment cap_cnt==len_q -> DONE next cycle.
REQ-021 CAPTURE with sample_vld, FIFO full and no same-cycle pop: sample dropped, cap_cnt not incremented, event_overflow pulses next cycle.
REQ-022 DONE: samples ignored; arm -> CAPTURE as in REQ-019 with FIFO contents retained.
REQ-023 arm while in CAPTURE SHALL be ignored.
REQ-024 flush in any state: FIFO pointers and fifo_count to 0, cap_cnt to 0, state to IDLE next cycle; flush has priority over arm, push and pop.
REQ-025 Pop SHALL occur when rd_req & rd_rdy; rd_data SHALL hold the popped word from the following cycle and remain unchanged until the next pop.
REQ-026 Simultaneous push and pop when full: both SHALL be accepted, fifo_count unchanged, no overflow.
REQ-027 Simultaneous push and pop when empty: push accepted, pop rejected, event_read_when_empty pulses next cycle.
REQ-028 Read and write pointers SHALL be FW bits and wrap modulo FIFO_SIZE; fifo_count SHALL range 0..FIFO_SIZE.
REQ-029 rd_rdy = (fifo_count != 0); busy/done decode directly from state.

Reset
REQ-030 On rstn low at a clock edge: state IDLE, pointers/fifo_count/cap_cnt/len_q 0, rd_data 0, event pulses 0, ovf_cnt 0; takes effect regardless of operation in progress.
REQ-031 FIFO storage array SHALL NOT require reset.

Configuration
REQ-032 Macro SAMPLE_STORE_OVF_CNT_EN defined: ovf_cnt increments by 1 on each event_overflow, saturates at 16'hFFFF, cleared by reset and flush.
REQ-033 Macro undefined: ovf_cnt tied to 16'h0000 and no counter logic synthesized; all other behaviour identical.

Verification
REQ-034 Reset then arm, capture_len=4, sample_vld for 6 cycles with 1..6 -> fifo_count=4, done=1, words 1..4 stored, 5/6 ignored.
REQ-035 FIFO_SIZE=8, capture_len=10, 10 samples, no reads -> 8 stored, two event_overflow pulses, ovf_cnt=2 with macro, 0 without, state stays CAPTURE.
REQ-036 Full FIFO, rd_req and sample_vld same cycle -> fifo_count stays 8, rd_data next cycle = oldest word, no overflow.
REQ-037 Empty FIFO, rd_req=1 -> event_read_when_empty pulses, rd_data unchanged, fifo_count 0.
REQ-038 Write/read 20 words through FIFO_SIZE=8 -> pointers wrap, read order 1..20 preserved.
REQ-039 flush mid-capture after 3 samples -> next cycle state IDLE, fifo_count 0, rd_rdy 0; rstn low mid-capture gives identical result.
